transport_rx: RTL

- Receive-side transport layer; mirror of the packet transmitter.
- Consumes the byte stream delivered by the link/FIFO layer, frames fixed-length packets by byte count, and decodes the header byte.
- Emits 16-bit control words and audio samples as single-cycle strobes with the original 2-bit cmd code.
- Sits between the byte-level link receiver and the call-control / audio playback logic.

---
 rtl/transport_pkg.sv | 29 ++
 rtl/transport_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/transport_pkg.sv
// Shared transport-layer definitions used by both the packet transmitter and
// the receiver (transport_rx).
//   - cmd codes carried alongside decoded words
//   - header byte values identifying packet type
//   - default packet geometry
//   - receiver FSM state type
package transport_pkg;

  localparam int unsigned PACKET_BYTES_DEFAULT  = 16;
  localparam int unsigned AUDIO_SAMPLES_DEFAULT = 7;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_AUDIO = 2'b10;

  localparam logic [7:0] HDR_CTRL  = 8'h40;
  localparam logic [7:0] HDR_AUDIO = 8'h80;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_CTRL_HI,
    ST_CTRL_LO,
    ST_AUD_HI,
    ST_AUD_LO,
    ST_PAD,
    ST_DROP
  } rx_state_t;

endpackage

// File: rtl/transport_rx.sv
// Receive-side transport layer. Frames fixed-length packets from the byte
// stream by count, decodes the header and emits 16-bit control words or audio
// samples as single-cycle strobes.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   byte_in      - incoming packet byte
//   byte_valid   - byte_in valid this cycle (always accepted)
//   flush        - abandon current packet, return to header hunt
//   out_cmd      - CMD_CTRL / CMD_AUDIO with out_valid, CMD_IDLE otherwise
//   out_data     - decoded word (hi byte first on the wire)
//   out_valid    - one-cycle strobe
//   out_last     - with out_valid: final word of the packet
//   busy         - mid-packet (state other than header hunt)
//   hdr_err      - one-cycle pulse: bad header, packet dropped
//   pad_err      - one-cycle pulse at packet end: nonzero padding seen
// PACKET_BYTES must be even and >= 4; 2*AUDIO_SAMPLES <= PACKET_BYTES-1.
module transport_rx
  import transport_pkg::*;
#(
  parameter int unsigned PACKET_BYTES  = PACKET_BYTES_DEFAULT,
  parameter int unsigned AUDIO_SAMPLES = AUDIO_SAMPLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        flush,
  output logic [1:0]  out_cmd,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic        hdr_err,
  output logic        pad_err
);

  localparam int unsigned CW = $clog2(PACKET_BYTES);
  localparam logic [CW-1:0] LAST_IDX        = CW'(PACKET_BYTES - 1);
  // Byte index of the lo byte of the final audio sample.
  localparam logic [CW-1:0] LAST_SAMPLE_IDX = CW'(2 * AUDIO_SAMPLES);
  localparam bit AUDIO_HAS_PAD = (2 * AUDIO_SAMPLES) < (PACKET_BYTES - 1);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [7:0]    hi_byte;
  logic          pad_flag;
  logic          last_byte;

  assign last_byte = (cnt == LAST_IDX);

  // busy is registered alongside every state transition so it tracks state
  // exactly without a combinational decode on the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HDR;
      cnt       <= '0;
      hi_byte   <= '0;
      pad_flag  <= 1'b0;
      out_cmd   <= CMD_IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      hdr_err   <= 1'b0;
      pad_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_cmd   <= CMD_IDLE;
      out_last  <= 1'b0;
      hdr_err   <= 1'b0;
      pad_err   <= 1'b0;

      if (flush) begin
        state    <= ST_HDR;
        busy     <= 1'b0;
        cnt      <= '0;
        pad_flag <= 1'b0;
      end else if (byte_valid) begin
        cnt <= last_byte ? '0 : cnt + 1'b1;

        unique case (state)
          ST_HDR: begin
            busy <= 1'b1;
            if (byte_in == HDR_CTRL) begin
              state <= ST_CTRL_HI;
            end else if (byte_in == HDR_AUDIO) begin
              state <= ST_AUD_HI;
            end else begin
              state   <= ST_DROP;
              hdr_err <= 1'b1;
            end
          end

          ST_CTRL_HI: begin
            hi_byte <= byte_in;
            state   <= ST_CTRL_LO;
          end

          ST_CTRL_LO: begin
            out_valid <= 1'b1;
            out_cmd   <= CMD_CTRL;
            out_data  <= {hi_byte, byte_in};
            out_last  <= 1'b1;
            state     <= ST_PAD;
          end

          ST_AUD_HI: begin
            hi_byte <= byte_in;
            state   <= ST_AUD_LO;
          end

          ST_AUD_LO: begin
            out_valid <= 1'b1;
            out_cmd   <= CMD_AUDIO;
            out_data  <= {hi_byte, byte_in};
            if (cnt == LAST_SAMPLE_IDX) begin
              out_last <= 1'b1;
              // With no padding bytes this lo byte is also the packet's last.
              if (AUDIO_HAS_PAD) begin
                state <= ST_PAD;
              end else begin
                state <= ST_HDR;
                busy  <= 1'b0;
              end
            end else begin
              state <= ST_AUD_HI;
            end
          end

          ST_PAD: begin
            if (last_byte) begin
              pad_err  <= pad_flag | (|byte_in);
              pad_flag <= 1'b0;
              state    <= ST_HDR;
              busy     <= 1'b0;
            end else begin
              pad_flag <= pad_flag | (|byte_in);
            end
          end

          ST_DROP: begin
            if (last_byte) begin
              state <= ST_HDR;
              busy  <= 1'b0;
            end
          end

          default: begin
            state <= ST_HDR;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
